multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath's mux selects, write enables and 3-bit ALUOp from a registered Moore FSM. It sits beside the shared single-ALU/single-memory datapath and replaces per-instruction combinational control with per-state control.

## Interface
Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock only.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode field from the instruction register (IR).
- zero  in  1  ALU zero flag; the datapath ANDs it with pc_write_cond.
- mem_ready  in  1  memory access complete; used only when MEM_WAIT_EN is defined.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  ALU B-input select: 0=reg B, 1=const 4, 2=sign-extended imm, 3=imm<<2.
- pc_source  out  2  next-PC select: 0=ALU result, 1=ALUOut, 2=jump target.
- alu_op  out  3  operation: 000=add, 001=sub, 010=use funct.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- trap  out  1  sticky flag for an illegal opcode.
- retire_count  out  RETIRE_W  count of completed instructions.

## Operation
- Opcodes: R-type 0, lw 35, sw 43, beq 4, j 2, addi 8. Any other opcode is illegal.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (computes the branch target). Next state is chosen by op:
  - lw or sw → MEM_ADDR
  - R-type → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EXEC
  - anything else → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Next state is MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state is FETCH.
- MEM_WR: mem_write=1, iord=1, instr_done=1. Next state is FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=funct. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1, instr_done=1. Next state is FETCH.
- JUMP: pc_write=1, pc_source=2, instr_done=1. Next state is FETCH.
- ADDI_EXEC: same controls as MEM_ADDR. Next state is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- TRAP: trap=1 and every other control is 0. The FSM stays in TRAP until rst.
- Any control not listed for a state is 0.
- retire_count increments by 1 on every cycle where instr_done=1. It wraps modulo 2^RETIRE_W without saturating.

## Timing
- Next-state logic and retire_count are registered. All control outputs are combinational decodes of the state register only (Moore). op and zero never feed the outputs directly.
- Reset:
  - While rst=1, every output is forced to 0 and retire_count is 0.
  - The first edge with rst=1 loads FETCH.
  - The first cycle with rst=0 is a FETCH cycle.
  - rst mid-instruction abandons the instruction without a pulse on instr_done or an increment of retire_count.
  - rst clears trap.
- Latency without wait states: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- op is sampled only in DECODE and MEM_ADDR. The IR must hold it stable from ir_write until the next FETCH.
- An unknown or X-valued state register recovers to FETCH on the next edge.
- When retire_count is at its maximum and instr_done=1, it becomes 0 on the next edge.

## Configuration
- MEM_WAIT_EN defined: FETCH, MEM_RD and MEM_WR hold while mem_ready=0.
  - The memory controls (mem_read, mem_write, iord) stay asserted and stable while the state holds.
  - In FETCH, pc_write and ir_write assert only in the cycle where mem_ready=1.
  - In MEM_WR, instr_done asserts only in the cycle where mem_ready=1.
  - The state advances on the edge ending a cycle with mem_ready=1.
  - A wait adds exactly N cycles for N low cycles of mem_ready.
- MEM_WAIT_EN undefined: mem_ready is ignored, and every memory state lasts exactly one cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit encoding);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alu_src_b and pc_source encodings.
- Sub-module ctrl_state_decode: purely combinational, mapping state (plus mem_ready under MEM_WAIT_EN) to the control word.
- The top level owns the state register, the next-state logic, trap and retire_count.

## Test plan
- Reset: rst=1 for 2 cycles with op=35 → all outputs 0 and retire_count=0. The first cycle after release shows FETCH controls (pc_write=1, ir_write=1, alu_src_b=1).
- Instruction sequence, no waits: lw(35), sw(43), R(0), addi(8), beq(4), j(2) back-to-back → instr_done pulses after 5, 4, 4, 4, 3, 3 cycles; retire_count=6; per-state controls match Operation.
- Illegal opcode: op=54 in DECODE → TRAP with trap=1 and all other outputs 0, held for 20 cycles. rst clears it and resumes at FETCH.
- Wait states (MEM_WAIT_EN): lw with mem_ready low 3 cycles in FETCH and 2 in MEM_RD → lw takes 10 cycles; pc_write/ir_write assert once; mem_read is continuous in the held states.
- Mid-instruction reset and counter wrap:
  - rst asserted in R_EXEC → no instr_done pulse, and FETCH follows release.
  - With RETIRE_W=4, 16 j instructions → retire_count returns to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] ALUB_REG     = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/ctrl_state_decode.sv
// Moore decode from FSM state to the datapath control word.
// With MEM_WAIT_EN defined, mem_ready qualifies the FETCH and MEM_WR side effects.
module ctrl_state_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
`ifdef MEM_WAIT_EN
  input  logic   mem_ready_i,
`endif
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
`ifdef MEM_WAIT_EN
        // PC and IR update only once the instruction word has actually arrived
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
`else
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
`endif
      end
      DECODE: begin
        ctrl_o.alu_src_b = ALUB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
`ifdef MEM_WAIT_EN
        ctrl_o.instr_done = mem_ready_i;
`else
        ctrl_o.instr_done = 1'b1;
`endif
      end
      R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      TRAP: begin
        ctrl_o.trap = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and retire counter.
// Define MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR until mem_ready is high.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [2:0]          alu_op,
  output logic                instr_done,
  output logic                trap,
  output logic [RETIRE_W-1:0] retire_count
);

  state_e                state_q, state_d;
  logic [RETIRE_W-1:0]   retire_q, retire_d;
  ctrl_t                 ctrlRaw;
  ctrl_t                 ctrl;
  logic                  memHold;
  logic                  unusedInputs;

`ifdef MEM_WAIT_EN
  assign memHold      = ~mem_ready;
  assign unusedInputs = zero;
`else
  assign memHold      = 1'b0;
  assign unusedInputs = &{1'b0, zero, mem_ready};
`endif

  ctrl_state_decode u_decode (
    .state_i     (state_q),
`ifdef MEM_WAIT_EN
    .mem_ready_i (mem_ready),
`endif
    .ctrl_o      (ctrlRaw)
  );

  // Reset overrides the decode so nothing leaks out while the state is being reloaded
  assign ctrl = rst ? '0 : ctrlRaw;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:     state_d = memHold ? FETCH : DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default:      state_d = TRAP;
        endcase
      end
      MEM_ADDR:  state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:    state_d = memHold ? MEM_RD : MEM_WB;
      MEM_WR:    state_d = memHold ? MEM_WR : FETCH;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
  end

  always_comb begin
    retire_d = retire_q;
    if (ctrlRaw.instr_done) retire_d = retire_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign trap          = ctrl.trap;
  assign retire_count  = rst ? '0 : retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (RETIRE_W=4 to exercise wrap).
// Wait-state vectors run only when MEM_WAIT_EN is defined.
module tb_multicycle_control;

  localparam int RW = 4;

  // Control word order: pcw,pwc,iord,mr,mw,irw,m2r,rdst,rw,asa | asb | pcs | aluop | done,trap
  localparam logic [18:0] W_FETCH      = {10'b1001010000, 2'd1, 2'd0, 3'b000, 2'b00};
  localparam logic [18:0] W_FETCH_WAIT = {10'b0001000000, 2'd1, 2'd0, 3'b000, 2'b00};
  localparam logic [18:0] W_DECODE     = {10'b0000000000, 2'd3, 2'd0, 3'b000, 2'b00};
  localparam logic [18:0] W_MEM_ADDR   = {10'b0000000001, 2'd2, 2'd0, 3'b000, 2'b00};
  localparam logic [18:0] W_MEM_RD     = {10'b0011000000, 2'd0, 2'd0, 3'b000, 2'b00};
  localparam logic [18:0] W_MEM_WB     = {10'b0000001010, 2'd0, 2'd0, 3'b000, 2'b10};
  localparam logic [18:0] W_MEM_WR     = {10'b0010100000, 2'd0, 2'd0, 3'b000, 2'b10};
  localparam logic [18:0] W_R_EXEC     = {10'b0000000001, 2'd0, 2'd0, 3'b010, 2'b00};
  localparam logic [18:0] W_R_WB       = {10'b0000000110, 2'd0, 2'd0, 3'b000, 2'b10};
  localparam logic [18:0] W_BRANCH     = {10'b0100000001, 2'd0, 2'd1, 3'b001, 2'b10};
  localparam logic [18:0] W_JUMP       = {10'b1000000000, 2'd0, 2'd2, 3'b000, 2'b10};
  localparam logic [18:0] W_ADDI_WB    = {10'b0000000010, 2'd0, 2'd0, 3'b000, 2'b10};
  localparam logic [18:0] W_TRAP       = {10'b0000000000, 2'd0, 2'd0, 3'b000, 2'b01};
  localparam logic [18:0] W_ZERO       = 19'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op;
  logic          zero;
  logic          memReady;
  logic          pcWrite, pcWriteCond, iord, memRead, memWrite, irWrite;
  logic          memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]    aluSrcB, pcSource;
  logic [2:0]    aluOp;
  logic          instrDone, trap;
  logic [RW-1:0] retireCount;
  logic [18:0]   ctrlObs;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .zero          (zero),
    .mem_ready     (memReady),
    .pc_write      (pcWrite),
    .pc_write_cond (pcWriteCond),
    .iord          (iord),
    .mem_read      (memRead),
    .mem_write     (memWrite),
    .ir_write      (irWrite),
    .mem_to_reg    (memToReg),
    .reg_dst       (regDst),
    .reg_write     (regWrite),
    .alu_src_a     (aluSrcA),
    .alu_src_b     (aluSrcB),
    .pc_source     (pcSource),
    .alu_op        (aluOp),
    .instr_done    (instrDone),
    .trap          (trap),
    .retire_count  (retireCount)
  );

  assign ctrlObs = {pcWrite, pcWriteCond, iord, memRead, memWrite, irWrite,
                    memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
                    aluOp, instrDone, trap};

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic m);
    rst      = r;
    op       = o;
    memReady = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int instrLen(input logic [5:0] opc);
    case (opc)
      6'd35:   return 5;
      6'd43:   return 4;
      6'd0:    return 4;
      6'd8:    return 4;
      6'd4:    return 3;
      default: return 3;
    endcase
  endfunction

  // Hand-written per-instruction state sequences
  function automatic logic [18:0] expWord(input logic [5:0] opc, input int idx);
    if (idx == 0) return W_FETCH;
    if (idx == 1) return W_DECODE;
    case (opc)
      6'd35:   return (idx == 2) ? W_MEM_ADDR : (idx == 3) ? W_MEM_RD : W_MEM_WB;
      6'd43:   return (idx == 2) ? W_MEM_ADDR : W_MEM_WR;
      6'd0:    return (idx == 2) ? W_R_EXEC : W_R_WB;
      6'd8:    return (idx == 2) ? W_MEM_ADDR : W_ADDI_WB;
      6'd4:    return W_BRANCH;
      default: return W_JUMP;
    endcase
  endfunction

  task automatic runInstr(input logic [5:0] opc, input string name);
    int len;
    len = instrLen(opc);
    applyStimulus(1'b0, opc, 1'b1);
    #1;
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s[%0d]", name, i), 32'(ctrlObs), 32'(expWord(opc, i)));
      step();
    end
  endtask

  initial begin
    zero = 1'b0;
    applyStimulus(1'b1, 6'd35, 1'b1);
    #1;
    checkOutput("rst_ctrl_pre", 32'(ctrlObs), 32'(W_ZERO));
    checkOutput("rst_cnt_pre", 32'(retireCount), 32'd0);
    step();
    checkOutput("rst_ctrl_1", 32'(ctrlObs), 32'(W_ZERO));
    checkOutput("rst_cnt_1", 32'(retireCount), 32'd0);
    step();

    runInstr(6'd35, "lw");
    runInstr(6'd43, "sw");
    runInstr(6'd0,  "rtype");
    runInstr(6'd8,  "addi");
    runInstr(6'd4,  "beq");
    runInstr(6'd2,  "j");
    checkOutput("retire_after_seq", 32'(retireCount), 32'd6);

    applyStimulus(1'b0, 6'd54, 1'b1);
    #1;
    checkOutput("ill_fetch", 32'(ctrlObs), 32'(W_FETCH));
    step();
    checkOutput("ill_decode", 32'(ctrlObs), 32'(W_DECODE));
    step();
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("trap_hold[%0d]", i), 32'(ctrlObs), 32'(W_TRAP));
      step();
    end
    checkOutput("trap_cnt", 32'(retireCount), 32'd6);
    applyStimulus(1'b1, 6'd54, 1'b1);
    #1;
    checkOutput("trap_rst_ctrl", 32'(ctrlObs), 32'(W_ZERO));
    checkOutput("trap_rst_cnt", 32'(retireCount), 32'd0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b1);
    #1;
    checkOutput("trap_resume", 32'(ctrlObs), 32'(W_FETCH));

    step();
    checkOutput("mid_decode", 32'(ctrlObs), 32'(W_DECODE));
    step();
    checkOutput("mid_rexec", 32'(ctrlObs), 32'(W_R_EXEC));
    applyStimulus(1'b1, 6'd0, 1'b1);
    #1;
    checkOutput("mid_rst_ctrl", 32'(ctrlObs), 32'(W_ZERO));
    step();
    checkOutput("mid_rst_nodone", 32'(instrDone), 32'd0);
    applyStimulus(1'b0, 6'd2, 1'b1);
    #1;
    checkOutput("mid_release", 32'(ctrlObs), 32'(W_FETCH));
    checkOutput("mid_cnt", 32'(retireCount), 32'd0);

    for (int k = 0; k < 16; k++) begin
      runInstr(6'd2, $sformatf("jwrap%0d", k));
      if (k == 14) checkOutput("wrap_15", 32'(retireCount), 32'd15);
    end
    checkOutput("wrap_0", 32'(retireCount), 32'd0);

`ifdef MEM_WAIT_EN
    applyStimulus(1'b0, 6'd35, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ws_fetch_wait[%0d]", i), 32'(ctrlObs), 32'(W_FETCH_WAIT));
      step();
    end
    memReady = 1'b1;
    #1;
    checkOutput("ws_fetch", 32'(ctrlObs), 32'(W_FETCH));
    step();
    checkOutput("ws_decode", 32'(ctrlObs), 32'(W_DECODE));
    step();
    checkOutput("ws_addr", 32'(ctrlObs), 32'(W_MEM_ADDR));
    step();
    memReady = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("ws_rd_wait[%0d]", i), 32'(ctrlObs), 32'(W_MEM_RD));
      step();
    end
    memReady = 1'b1;
    #1;
    checkOutput("ws_rd", 32'(ctrlObs), 32'(W_MEM_RD));
    step();
    checkOutput("ws_wb", 32'(ctrlObs), 32'(W_MEM_WB));
    step();
    checkOutput("ws_cnt", 32'(retireCount), 32'd1);
    checkOutput("ws_next_fetch", 32'(ctrlObs), 32'(W_FETCH));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
